parallel2serial: RTL and testbench



---
 rtl/parallel2serial_pkg.sv | 23 ++
 rtl/parallel2serial_bit_timer.sv | 27 ++
 rtl/parallel2serial.sv | 119 +++++++++++
 tb/tb_parallel2serial.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/parallel2serial_pkg.sv
// Frame layout and state encoding for the 11-bit serial keyboard-style link.
// Shared by the transmitter and the serial2parallel receiver.
package parallel2serial_pkg;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic PARITY_ODD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bit 0 goes on the wire first: start, data LSB..MSB, parity, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
    logic parity;
    parity = PARITY_ODD ? ~^data : ^data;
    return {STOP_BIT, parity, data, START_BIT};
  endfunction

endpackage

// File: rtl/parallel2serial_bit_timer.sv
// Counts clock cycles within one serial bit period; tick marks the last cycle.
// Shared between data-bit timing and guard-gap timing.
module bit_timer #(
  parameter int BIT_CYCLES = 8000
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(BIT_CYCLES);

  logic [CW-1:0] count_reg;

  assign tick = enable && (count_reg == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? '0 : count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/parallel2serial.sv
// Byte-to-serial transmitter: valid/ready byte in, 11-bit odd-parity frame out
// LSB first on o1b, followed by GAP_BITS idle-high bit periods.
module parallel2serial
  import parallel2serial_pkg::*;
#(
  parameter int BIT_CYCLES = 8000,
  parameter int GAP_BITS   = 2
) (
  input  logic       Clock50,
  input  logic       iReset,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic       o1b,
  output logic       oDone
);

  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  state_t                state_reg, state_next;
  logic [FRAME_BITS-1:0] frame_reg;
  logic [3:0]            bit_idx_reg, bit_idx_next;
  logic [GW-1:0]         gap_idx_reg, gap_idx_next;
  logic                  o1b_reg, o1b_next;
  logic                  done_reg, done_next;
  logic                  ready_reg, ready_next;
  logic                  accept, tick, timer_clear, timer_enable;
  logic                  last_bit, last_gap;

  // ready_reg is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept   = iValid && ready_reg;
  assign last_bit = (bit_idx_reg == 4'(FRAME_BITS - 1));
  assign last_gap = (gap_idx_reg == GW'(GAP_BITS - 1));

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk   (Clock50),
    .srst  (iReset),
    .clear (timer_clear),
    .enable(timer_enable),
    .tick  (tick)
  );

  always_ff @(posedge Clock50) begin
    if (iReset) begin
      state_reg   <= ST_IDLE;
      frame_reg   <= '0;
      bit_idx_reg <= '0;
      gap_idx_reg <= '0;
      o1b_reg     <= 1'b1;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      gap_idx_reg <= gap_idx_next;
      o1b_reg     <= o1b_next;
      done_reg    <= done_next;
      ready_reg   <= ready_next;
      if (accept) begin
        frame_reg <= make_frame(iData);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    gap_idx_next = gap_idx_reg;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (accept) begin
          state_next   = ST_SEND;
          bit_idx_next = '0;
          gap_idx_next = '0;
        end
      end
      ST_SEND: begin
        timer_enable = 1'b1;
        if (tick) begin
          if (last_bit) begin
            bit_idx_next = '0;
            gap_idx_next = '0;
            state_next   = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
          end
        end
      end
      ST_GAP: begin
        timer_enable = 1'b1;
        if (tick) begin
          if (last_gap) begin
            state_next = ST_IDLE;
          end else begin
            gap_idx_next = gap_idx_reg + GW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered, so the line lags the state by one cycle and never glitches.
  always_comb begin
    o1b_next   = (state_reg == ST_SEND) ? frame_reg[bit_idx_reg] : STOP_BIT;
    done_next  = (state_reg == ST_SEND) && tick && last_bit;
    ready_next = (state_reg == ST_IDLE) && !accept;
  end

  assign o1b    = o1b_reg;
  assign oDone  = done_reg;
  assign oReady = ready_reg;

endmodule

// File: tb/tb_parallel2serial.sv
// Randomised and directed checks of parallel2serial against a cycle-timeline
// model derived from the frame rules (bit k spans edges T+1+k*B .. T+(k+1)*B).
module tb_parallel2serial;

  localparam int BC = 4;
  localparam int GB = 2;
  localparam int FB = 11;
  localparam int READY_AT = 1 + (FB + GB) * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       ready, line, done;

  always #5 clk = ~clk;

  parallel2serial #(
    .BIT_CYCLES(BC),
    .GAP_BITS  (GB)
  ) dut (
    .Clock50(clk),
    .iReset (rst),
    .iData  (data),
    .iValid (valid),
    .oReady (ready),
    .o1b    (line),
    .oDone  (done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  bit m_busy = 1'b0;
  int m_since = 0;
  bit m_frame[FB];
  bit m_ready = 1'b1;
  bit m_line = 1'b1;
  bit m_done = 1'b0;
  bit m_accepted = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cycle, obs, exp_v);
    end
  endtask

  // Advance the reference model by one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    bit prev_ready;
    int ones;
    prev_ready = m_ready;
    m_accepted = 1'b0;
    m_done     = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      m_ready = 1'b1;
      m_line  = 1'b1;
    end else if (m_busy) begin
      m_since++;
      m_line = (m_since >= 1 && m_since <= FB * BC) ? m_frame[(m_since - 1) / BC] : 1'b1;
      m_done = (m_since == FB * BC);
      if (m_since >= READY_AT) begin
        m_busy  = 1'b0;
        m_ready = 1'b1;
      end
    end else if (valid && prev_ready) begin
      ones = 0;
      m_frame[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_frame[i + 1] = data[i];
        ones += int'(data[i]);
      end
      m_frame[9]  = (ones % 2 == 0);
      m_frame[10] = 1'b1;
      m_busy     = 1'b1;
      m_since    = 0;
      m_ready    = 1'b0;
      m_line     = 1'b1;
      m_accepted = 1'b1;
      $display("frame 0x%02h accepted at cycle %0d", data, cycle);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    model_edge();
    #1;
    chk("o1b", line, m_line);
    chk("oReady", ready, m_ready);
    chk("oDone", done, m_done);
  endtask

  task automatic start_frame(input logic [7:0] d);
    int n;
    valid = 1'b1;
    data  = d;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_accepted && n < 200);
    chk("accept_timeout", m_accepted, 1'b1);
    valid = 1'b0;
    data  = 8'($urandom);
  endtask

  task automatic finish_frame();
    int n;
    n = 0;
    while (m_busy && n < 200) begin
      valid = 1'($urandom_range(0, 1));
      data  = 8'($urandom);
      step();
      n++;
    end
    valid = 1'b0;
    chk("frame_timeout", m_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] directed [6];
    directed = '{8'h8B, 8'h0F, 8'h61, 8'h00, 8'hFF, 8'h3C};

    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    repeat (100) step();

    foreach (directed[i]) begin
      start_frame(directed[i]);
      finish_frame();
      repeat (3) step();
    end

    // Busy and back-to-back: iData changes every cycle while iValid stays high.
    valid = 1'b1;
    for (int i = 0; i < 5 * READY_AT + 10; i++) begin
      data = 8'($urandom);
      step();
    end
    valid = 1'b0;
    finish_frame();

    // Reset during data bit 3 (frame bit 4) of 0xA5, then a clean 0x3C.
    start_frame(8'hA5);
    repeat (4 * BC + 2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    start_frame(8'h3C);
    finish_frame();

    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      rst   = ($urandom_range(0, 499) == 0);
      step();
    end
    rst   = 1'b0;
    valid = 1'b0;
    repeat (2 * READY_AT) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
